// File: rtl/spw_ulight_pkg.sv
// rtl/spw_ulight_pkg.sv - shared character encodings and capture-FSM states for the uLight receive path
package spw_ulight_pkg;

    localparam int DW_DEFAULT = 9;

    localparam logic [8:0] CHAR_EOP = 9'h100;
    localparam logic [8:0] CHAR_EEP = 9'h101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAKE = 2'd1,
        ST_GAP  = 2'd2
    } cap_state_e;

endpackage

// File: rtl/spw_ulight_rx_holding_if.sv
// rtl/spw_ulight_rx_holding_if.sv - codec receive handshake plus software-side PIO signals of the holding buffer
interface spw_ulight_rx_holding_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 9
);
    localparam int FW = $clog2(DEPTH) + 1;

    logic          rx_valid;
    logic [DW-1:0] rx_data;
    logic          rx_read;
    logic [DW-1:0] data_out;
    logic          data_ready;
    logic          sw_ack;
    logic          sts_clr;
    logic [FW-1:0] fill;
    logic          eop_seen;
    logic          eep_seen;
    logic          underflow;

    modport master (
        output rx_valid, rx_data, sw_ack, sts_clr,
        input  rx_read, data_out, data_ready, fill, eop_seen, eep_seen, underflow
    );

    modport slave (
        input  rx_valid, rx_data, sw_ack, sts_clr,
        output rx_read, data_out, data_ready, fill, eop_seen, eep_seen, underflow
    );
endinterface

// File: rtl/spw_ulight_sync_fifo.sv
// rtl/spw_ulight_sync_fifo.sv - small synchronous FIFO with extra-MSB pointers and a registered head output
module spw_ulight_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 9,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] head,
    output logic          empty,
    output logic          full,
    output logic [PW-1:0] fill
);
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_nxt;
    logic          do_wr;
    logic          do_rd;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fill       = wr_ptr - rd_ptr;
    assign do_wr      = wr_en & ~full;
    assign do_rd      = rd_en & ~empty;
    assign rd_ptr_nxt = rd_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PW'(1);
            if (do_rd) rd_ptr <= rd_ptr_nxt;
        end
    end

    // Head only moves on a pop or a push into an empty FIFO; a pop of the last
    // entry hands over to a same-cycle push, otherwise the FIFO goes empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
        end else if (do_rd) begin
            if (fill == PW'(1)) begin
                head <= do_wr ? wr_data : '0;
            end else begin
                head <= mem[rd_ptr_nxt[AW-1:0]];
            end
        end else if (do_wr && empty) begin
            head <= wr_data;
        end
    end
endmodule

// File: rtl/spw_ulight_rx_holding.sv
// rtl/spw_ulight_rx_holding.sv - receive holding buffer between the SpaceWire codec and the receive-data PIO
module spw_ulight_rx_holding
    import spw_ulight_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = DW_DEFAULT
) (
    input logic                    clk,
    input logic                    reset_n,
    spw_ulight_rx_holding_if.slave bus
);
    cap_state_e state;
    logic       ack_q;
    logic       push;
    logic       pop;
    logic       empty;
    logic       full;
    logic       set_eop;
    logic       set_eep;
    logic       set_unf;

    assign push    = (state == ST_TAKE);
    assign pop     = bus.sw_ack & ~ack_q;
    assign set_eop = push && (bus.rx_data == DW'(CHAR_EOP));
    assign set_eep = push && (bus.rx_data == DW'(CHAR_EEP));
    assign set_unf = pop && empty;
    assign bus.data_ready = ~empty;

    // The GAP state gives the codec a cycle to drop or renew rx_valid before
    // IDLE samples it again.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            bus.rx_read <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.rx_valid && !full) begin
                        state       <= ST_TAKE;
                        bus.rx_read <= 1'b1;
                    end
                end
                ST_TAKE: begin
                    state       <= ST_GAP;
                    bus.rx_read <= 1'b0;
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state       <= ST_IDLE;
                    bus.rx_read <= 1'b0;
                end
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as sts_clr wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q         <= 1'b0;
            bus.eop_seen  <= 1'b0;
            bus.eep_seen  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            ack_q <= bus.sw_ack;
            if (set_eop)          bus.eop_seen <= 1'b1;
            else if (bus.sts_clr) bus.eop_seen <= 1'b0;
            if (set_eep)          bus.eep_seen <= 1'b1;
            else if (bus.sts_clr) bus.eep_seen <= 1'b0;
            if (set_unf)          bus.underflow <= 1'b1;
            else if (bus.sts_clr) bus.underflow <= 1'b0;
        end
    end

    spw_ulight_sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (push),
        .wr_data (bus.rx_data),
        .rd_en   (pop),
        .head    (bus.data_out),
        .empty   (empty),
        .full    (full),
        .fill    (bus.fill)
    );
endmodule

// File: tb/tb_spw_ulight_rx_holding.sv
// tb/tb_spw_ulight_rx_holding.sv - directed self-checking bench for the receive holding buffer
module tb_spw_ulight_rx_holding;
    localparam int DEPTH = 4;
    localparam int DW    = 9;

    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   rd_pulses = 0;
    int   base;
    logic found;
    logic [DW-1:0] codec_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] v;

    spw_ulight_rx_holding_if #(.DEPTH(DEPTH), .DW(DW)) bus ();

    spw_ulight_rx_holding #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_pop();
        bus.sw_ack = 1'b0;
        tick(1);
        bus.sw_ack = 1'b1;
        tick(1);
    endtask

    // Codec model: offers the head of codec_q, retires it after an rx_read pulse.
    initial begin
        logic rd_seen;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        forever begin
            @(negedge clk);
            rd_seen = bus.rx_read;
            if (rd_seen) rd_pulses++;
            @(posedge clk);
            #1;
            if (rd_seen && codec_q.size() > 0) void'(codec_q.pop_front());
            bus.rx_valid = (codec_q.size() > 0);
            bus.rx_data  = (codec_q.size() > 0) ? codec_q[0] : '0;
        end
    end

    initial begin
        reset_n     = 1'b0;
        bus.sw_ack  = 1'b0;
        bus.sts_clr = 1'b0;
        tick(2);
        check("rst_rx_read",    bus.rx_read,    0);
        check("rst_data_out",   bus.data_out,   0);
        check("rst_data_ready", bus.data_ready, 0);
        check("rst_fill",       bus.fill,       0);
        check("rst_flags",      {bus.eop_seen, bus.eep_seen, bus.underflow}, 0);
        reset_n = 1'b1;
        tick(1);

        base = rd_pulses;
        codec_q.push_back(9'h0A5);
        tick(6);
        check("one_pulses",     rd_pulses - base, 1);
        check("one_data_out",   bus.data_out,     9'h0A5);
        check("one_data_ready", bus.data_ready,   1);
        check("one_fill",       bus.fill,         1);
        do_pop();
        check("one_pop_fill",   bus.fill,         0);
        check("one_pop_data",   bus.data_out,     0);
        check("one_pop_ready",  bus.data_ready,   0);

        base = rd_pulses;
        for (int i = 1; i <= 5; i++) codec_q.push_back(DW'(i));
        tick(30);
        check("full_pulses",    rd_pulses - base, 4);
        check("full_fill",      bus.fill,         4);
        check("full_head",      bus.data_out,     9'h001);
        check("full_held",      bus.rx_valid,     1);
        do_pop();
        check("full_pop_head",  bus.data_out,     9'h002);
        check("full_pop_fill",  bus.fill,         3);
        tick(6);
        check("fifth_pulses",   rd_pulses - base, 5);
        check("fifth_fill",     bus.fill,         4);
        do_pop();
        check("drain_3",        bus.data_out,     9'h003);
        do_pop();
        check("drain_4",        bus.data_out,     9'h004);
        do_pop();
        check("drain_5",        bus.data_out,     9'h005);
        do_pop();
        check("drain_empty",    bus.data_out,     0);
        check("drain_fill",     bus.fill,         0);

        do_pop();
        check("unf_set",        bus.underflow,    1);
        check("unf_fill",       bus.fill,         0);
        bus.sts_clr = 1'b1;
        tick(1);
        bus.sts_clr = 1'b0;
        check("unf_clr",        bus.underflow,    0);

        codec_q.push_back(9'h100);
        codec_q.push_back(9'h101);
        tick(12);
        check("mk_eop",         bus.eop_seen,     1);
        check("mk_eep",         bus.eep_seen,     1);
        check("mk_fill",        bus.fill,         2);
        check("mk_head",        bus.data_out,     9'h100);
        do_pop();
        check("mk_head2",       bus.data_out,     9'h101);
        do_pop();
        bus.sts_clr = 1'b1;
        tick(1);
        bus.sts_clr = 1'b0;
        check("mk_clr",         {bus.eop_seen, bus.eep_seen}, 0);
        codec_q.push_back(9'h102);
        tick(6);
        check("mk_other_flags", {bus.eop_seen, bus.eep_seen}, 0);
        check("mk_other_head",  bus.data_out,     9'h102);
        do_pop();

        bus.sw_ack = 1'b0;
        codec_q.push_back(9'h0AA);
        codec_q.push_back(9'h0BB);
        tick(12);
        check("sim_pre_fill",   bus.fill,         2);
        codec_q.push_back(9'h0CC);
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.rx_read) begin
                found = 1'b1;
                break;
            end
        end
        check("sim_take_seen",  found,            1);
        check("sim_take_fill",  bus.fill,         2);
        bus.sw_ack = 1'b1;
        @(posedge clk);
        #1;
        check("sim_post_fill",  bus.fill,         2);
        check("sim_post_head",  bus.data_out,     9'h0BB);

        exp_q = '{9'h0BB, 9'h0CC};
        for (int i = 0; i < 12; i++) begin
            v = DW'(9'h040 + i);
            codec_q.push_back(v);
            exp_q.push_back(v);
            tick(6);
            do_pop();
            void'(exp_q.pop_front());
            check("wrap_head",  bus.data_out,     exp_q[0]);
        end
        check("wrap_fill",      bus.fill,         2);
        do_pop();
        check("wrap_last",      bus.data_out,     9'h04B);
        do_pop();
        check("wrap_empty",     bus.data_ready,   0);

        codec_q.push_back(9'h100);
        codec_q.push_back(9'h011);
        codec_q.push_back(9'h022);
        tick(14);
        check("ar_pre_fill",    bus.fill,         3);
        check("ar_pre_eop",     bus.eop_seen,     1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_rx_read",     bus.rx_read,      0);
        check("ar_data_out",    bus.data_out,     0);
        check("ar_data_ready",  bus.data_ready,   0);
        check("ar_fill",        bus.fill,         0);
        check("ar_flags",       {bus.eop_seen, bus.eep_seen, bus.underflow}, 0);
        tick(1);
        reset_n = 1'b1;
        tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spw_ulight_rx_holding.md
# spw_ulight_rx_holding

Receive-side holding buffer between the SpaceWire codec receive interface and the 9-bit receive-data PIO that software reads over Avalon. It takes characters from the codec with a valid/read handshake and queues them in a small FIFO. It presents the head entry as a stable level on `data_out` and pops on a software acknowledge edge. It also flags end-of-packet and error-end-of-packet arrivals for the status PIO.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `DW`, default 9: character width; bit 8 is the control flag, bits 7:0 are data.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  codec holds a character on `rx_data`.
- `rx_data`  in  DW  codec character; held stable while `rx_valid` = 1.
- `rx_read`  out  1  one-cycle pulse; character consumed from the codec.
- `data_out`  out  DW  head-of-FIFO character; drives the receive-data PIO `in_port`.
- `data_ready`  out  1  FIFO non-empty.
- `sw_ack`  in  1  level from a software-written PIO; each rising edge pops one entry.
- `sts_clr`  in  1  synchronous clear of the sticky flags.
- `fill`  out  $clog2(DEPTH)+1  current occupancy.
- `eop_seen`  out  1  sticky: an EOP was pushed.
- `eep_seen`  out  1  sticky: an EEP was pushed.
- `underflow`  out  1  sticky: pop requested while empty.

## Operation
- Capture FSM has three states.
  - IDLE: if `rx_valid` = 1 and the FIFO is not full, go to TAKE.
  - TAKE: write `rx_data` at `wr_ptr`, assert `rx_read` for exactly this cycle, increment `wr_ptr`, go to GAP.
  - GAP: always return to IDLE. The gap gives the codec one cycle to drop or renew `rx_valid`.
- Full FIFO: the FSM stays in IDLE and `rx_read` stays 0. The codec holds the character, so no data is lost.
- Pop:
  - `ack_q` registers `sw_ack`; the pop strobe is `sw_ack & ~ack_q`.
  - Pop while non-empty: `rd_ptr` increments.
  - Pop while empty: pointers unchanged and `underflow` is set.
- Push and pop in the same cycle: both occur and `fill` is unchanged.
- Pointers:
  - Both pointers are `$clog2(DEPTH)`+1 bits and wrap modulo 2·DEPTH.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the low bits are equal.
  - `fill` = `wr_ptr` − `rd_ptr`, modulo 2·DEPTH.
- Marker detection on each push:
  - `rx_data` = 9'h100 sets `eop_seen`.
  - `rx_data` = 9'h101 sets `eep_seen`.
  - Other control characters set neither flag.
- `sts_clr` = 1 clears all sticky flags. If a set event occurs in the same cycle as the clear, the set wins.
- `data_out` is registered:
  - It equals `mem[rd_ptr]` when non-empty.
  - It is 0 when empty.
  - It changes only on a push into an empty FIFO or on a pop.

## Timing
- Reset values: `rx_read` 0, `data_out` 0, `data_ready` 0, `fill` 0, `eop_seen` 0, `eep_seen` 0, `underflow` 0. FSM state is IDLE, pointers are 0 and `ack_q` is 0.
- Mid-operation reset discards queued characters. A codec character not yet read stays with the codec.
- Codec handshake:
  - `rx_valid` rises at cycle n while the FIFO has room; `rx_read` = 1 at n+1.
  - `data_out` and `data_ready` reflect the character at n+2 when the FIFO was empty.
- Pop: `sw_ack` rises at cycle n; the new `data_out` and `fill` appear at n+1.
- Maximum capture rate is one character per 3 cycles. There is no throughput constraint beyond the codec rate.
- `sw_ack` is generated in the `clk` domain, so no synchroniser is needed.

## Structure
- The shared package `spw_ulight_pkg` holds:
  - the `DW` default;
  - the EOP/EEP encodings `CHAR_EOP` = 9'h100 and `CHAR_EEP` = 9'h101;
  - the capture-FSM state enum.
- One sub-module: `spw_ulight_sync_fifo` (parameterised DEPTH/DW storage, pointers, full/empty/fill).
- The top level holds the capture FSM, the ack edge detect and the sticky flags.

## Test plan
- Reset release, then 9'h0A5 presented with `rx_valid` held → `rx_read` pulses once; `data_out` = 9'h0A5, `data_ready` = 1, `fill` = 1.
- Push 5 characters 9'h001..9'h005 with DEPTH = 4 and no acks → 4 `rx_read` pulses and `fill` = 4. `rx_valid` stays high with 9'h005 held. After one `sw_ack` edge, the 5th character is read; `data_out` steps 9'h001 → 9'h002.
- `sw_ack` rising edge while empty → `underflow` = 1 and `fill` stays 0. Then `sts_clr` → `underflow` = 0.
- Push 9'h100 then 9'h101 → `eop_seen` = 1 and `eep_seen` = 1; the data bytes queue normally. Push 9'h102 alone after `sts_clr` → both flags stay 0.
- Push and pop in the same cycle with `fill` = 2 → `fill` stays 2; pointer wrap exercised across more than 2·DEPTH transfers with data integrity checked.
- Assert `reset_n` low with `fill` = 3 → all outputs return to their reset values immediately, asynchronously.
